resv_station_gen: RTL and testbench

- Parametrised, depth-generic reservation station with a compacting age-ordered queue; entry 0 is always the oldest.
- Captures operands from N_WB writeback broadcast buses.
- Issues up to two ready micro-ops per cycle (oldest-ready first) through independent valid/accept handshakes.
- Sits between decode/rename and the execution pipes. Successor of the fixed 8-entry single-update station.

---
 rtl/resv_station_gen_if.sv | 49 ++++
 rtl/resv_station_gen.sv | 135 +++++++++++++
 tb/tb_resv_station_gen.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/resv_station_gen_if.sv
// Bundle of the insert, writeback-broadcast, issue and status signals of resv_station_gen.
// master = upstream/pipe side, slave = the reservation station.
interface resv_station_gen_if #(
   parameter int W_CNT      = 4,
   parameter int N_WB       = 2,
   parameter int W_PD_UOPS  = 6,
   parameter int W_PD_DATA  = 32,
   parameter int W_PA_REG   = 5,
   parameter int W_AA_INSTR = 32
);
   // Handshakes: insert is taken when DFI_PV_in && !CFO_PC_full && !CFI_PC_stall;
   // an issue port retires its entry when DFO_PV_issN && CFI_PC_accN at the same edge.
   logic                       DFI_PV_in;
   logic [W_PD_UOPS-1:0]       DFI_PD_uops;
   logic [W_PA_REG-1:0]        DFI_PA_rd, DFI_PA_rs, DFI_PA_rt;
   logic                       DFI_PV_rs, DFI_PV_rt;
   logic [W_PD_DATA-1:0]       DFI_PD_rs, DFI_PD_rt, DFI_PD_imm;
   logic [W_AA_INSTR-1:0]      DFI_AA_pc;
   logic [N_WB-1:0]            CDI_PV_wb;
   logic [N_WB*W_PA_REG-1:0]   CDI_PA_wb;
   logic [N_WB*W_PD_DATA-1:0]  CDI_PD_wb;
   logic                       CFI_PC_stall, CFI_PC_acc0, CFI_PC_acc1;
   logic                       DFO_PV_iss0, DFO_PV_iss1;
   logic [W_PD_UOPS-1:0]       DFO_PD_uops0, DFO_PD_uops1;
   logic [W_PD_DATA-1:0]       DFO_PD_rs0, DFO_PD_rs1, DFO_PD_rt0, DFO_PD_rt1;
   logic [W_PD_DATA-1:0]       DFO_PD_imm0, DFO_PD_imm1;
   logic [W_PA_REG-1:0]        DFO_PA_rd0, DFO_PA_rd1;
   logic [W_AA_INSTR-1:0]      DFO_AA_pc0, DFO_AA_pc1;
   logic                       CFO_PC_full, CFO_PC_empty;
   logic [W_CNT-1:0]           CDO_PS_count;

   modport master (
      output DFI_PV_in, DFI_PD_uops, DFI_PA_rd, DFI_PA_rs, DFI_PA_rt, DFI_PV_rs, DFI_PV_rt,
             DFI_PD_rs, DFI_PD_rt, DFI_PD_imm, DFI_AA_pc, CDI_PV_wb, CDI_PA_wb, CDI_PD_wb,
             CFI_PC_stall, CFI_PC_acc0, CFI_PC_acc1,
      input  DFO_PV_iss0, DFO_PV_iss1, DFO_PD_uops0, DFO_PD_uops1, DFO_PD_rs0, DFO_PD_rs1,
             DFO_PD_rt0, DFO_PD_rt1, DFO_PD_imm0, DFO_PD_imm1, DFO_PA_rd0, DFO_PA_rd1,
             DFO_AA_pc0, DFO_AA_pc1, CFO_PC_full, CFO_PC_empty, CDO_PS_count
   );

   modport slave (
      input  DFI_PV_in, DFI_PD_uops, DFI_PA_rd, DFI_PA_rs, DFI_PA_rt, DFI_PV_rs, DFI_PV_rt,
             DFI_PD_rs, DFI_PD_rt, DFI_PD_imm, DFI_AA_pc, CDI_PV_wb, CDI_PA_wb, CDI_PD_wb,
             CFI_PC_stall, CFI_PC_acc0, CFI_PC_acc1,
      output DFO_PV_iss0, DFO_PV_iss1, DFO_PD_uops0, DFO_PD_uops1, DFO_PD_rs0, DFO_PD_rs1,
             DFO_PD_rt0, DFO_PD_rt1, DFO_PD_imm0, DFO_PD_imm1, DFO_PA_rd0, DFO_PA_rd1,
             DFO_AA_pc0, DFO_AA_pc1, CFO_PC_full, CFO_PC_empty, CDO_PS_count
   );
endinterface

// File: rtl/resv_station_gen.sv
// Depth-generic reservation station: compacting age-ordered queue (entry 0 oldest),
// N_WB-bus operand wakeup, dual oldest-ready-first issue ports.
module resv_station_gen #(
   parameter int DEPTH      = 8,
   parameter int W_CNT      = 4,
   parameter int N_WB       = 2,
   parameter int W_PD_UOPS  = 6,
   parameter int W_PD_DATA  = 32,
   parameter int W_PA_REG   = 5,
   parameter int W_AA_INSTR = 32
) (
   input logic                clk,
   input logic                CFI_PC_clear,
   resv_station_gen_if.slave  rs_if
);
   localparam int W_IDX = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic                  v;
      logic [W_PD_UOPS-1:0]  uops;
      logic [W_PA_REG-1:0]   rd;
      logic                  rs_v;
      logic [W_PA_REG-1:0]   rs_a;
      logic [W_PD_DATA-1:0]  rs_d;
      logic                  rt_v;
      logic [W_PA_REG-1:0]   rt_a;
      logic [W_PD_DATA-1:0]  rt_d;
      logic [W_PD_DATA-1:0]  imm;
      logic [W_AA_INSTR-1:0] pc;
   } entry_t;

   entry_t            ent [DEPTH];
   entry_t            nxt [DEPTH];
   logic [W_CNT-1:0]  count, count_nxt, rem_cnt;
   logic [DEPTH-1:0]  rdy;
   logic              found0, found1, iss0, iss1, rem0, rem1, ins, full;
   logic [W_IDX-1:0]  sel0, sel1, dst, ins_pos;
   logic [1:0]        shift;

   // Select looks only at registered state, so a wakeup becomes issuable one cycle later.
   always_comb begin
      found0 = 1'b0;
      found1 = 1'b0;
      sel0   = '0;
      sel1   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rdy[i] = ent[i].v && ent[i].rs_v && ent[i].rt_v;
         if (rdy[i] && !found0) begin
            found0 = 1'b1;
            sel0   = W_IDX'(i);
         end else if (rdy[i] && !found1) begin
            found1 = 1'b1;
            sel1   = W_IDX'(i);
         end
      end
   end

   assign full    = (count == W_CNT'(DEPTH));
   assign iss0    = found0 && !rs_if.CFI_PC_stall;
   assign iss1    = found1 && !rs_if.CFI_PC_stall;
   assign rem0    = iss0 && rs_if.CFI_PC_acc0;
   assign rem1    = iss1 && rs_if.CFI_PC_acc1;
   assign ins     = rs_if.DFI_PV_in && !full && !rs_if.CFI_PC_stall;
   assign rem_cnt = W_CNT'(rem0) + W_CNT'(rem1);
   assign ins_pos = W_IDX'(count - rem_cnt);
   assign count_nxt = count - rem_cnt + W_CNT'(ins);

   // Next image: squeeze out retired entries, append the insert, then snoop the buses.
   always_comb begin
      shift = '0;
      dst   = '0;
      for (int j = 0; j < DEPTH; j++) nxt[j] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent[i].v && ((rem0 && sel0 == W_IDX'(i)) || (rem1 && sel1 == W_IDX'(i)))) begin
            shift = shift + 2'd1;
         end else if (ent[i].v) begin
            dst      = W_IDX'(i) - W_IDX'(shift);
            nxt[dst] = ent[i];
         end
      end
      if (ins) begin
         nxt[ins_pos] = '{v: 1'b1, uops: rs_if.DFI_PD_uops, rd: rs_if.DFI_PA_rd,
                          rs_v: rs_if.DFI_PV_rs, rs_a: rs_if.DFI_PA_rs, rs_d: rs_if.DFI_PD_rs,
                          rt_v: rs_if.DFI_PV_rt, rt_a: rs_if.DFI_PA_rt, rt_d: rs_if.DFI_PD_rt,
                          imm: rs_if.DFI_PD_imm, pc: rs_if.DFI_AA_pc};
      end
      // Buses scanned high to low so the lowest-index match is written last and wins.
      for (int j = 0; j < DEPTH; j++) begin
         if (nxt[j].v && !nxt[j].rs_v) begin
            for (int b = N_WB - 1; b >= 0; b--) begin
               if (rs_if.CDI_PV_wb[b] && rs_if.CDI_PA_wb[b*W_PA_REG +: W_PA_REG] == nxt[j].rs_a) begin
                  nxt[j].rs_v = 1'b1;
                  nxt[j].rs_d = rs_if.CDI_PD_wb[b*W_PD_DATA +: W_PD_DATA];
               end
            end
         end
         if (nxt[j].v && !nxt[j].rt_v) begin
            for (int b = N_WB - 1; b >= 0; b--) begin
               if (rs_if.CDI_PV_wb[b] && rs_if.CDI_PA_wb[b*W_PA_REG +: W_PA_REG] == nxt[j].rt_a) begin
                  nxt[j].rt_v = 1'b1;
                  nxt[j].rt_d = rs_if.CDI_PD_wb[b*W_PD_DATA +: W_PD_DATA];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (CFI_PC_clear) begin
         for (int j = 0; j < DEPTH; j++) ent[j].v <= 1'b0;
         count <= '0;
      end else begin
         for (int j = 0; j < DEPTH; j++) ent[j] <= nxt[j];
         count <= count_nxt;
      end
   end

   assign rs_if.DFO_PV_iss0  = iss0;
   assign rs_if.DFO_PV_iss1  = iss1;
   assign rs_if.DFO_PD_uops0 = iss0 ? ent[sel0].uops : '1;
   assign rs_if.DFO_PD_uops1 = iss1 ? ent[sel1].uops : '1;
   assign rs_if.DFO_PD_rs0   = iss0 ? ent[sel0].rs_d : '0;
   assign rs_if.DFO_PD_rs1   = iss1 ? ent[sel1].rs_d : '0;
   assign rs_if.DFO_PD_rt0   = iss0 ? ent[sel0].rt_d : '0;
   assign rs_if.DFO_PD_rt1   = iss1 ? ent[sel1].rt_d : '0;
   assign rs_if.DFO_PD_imm0  = iss0 ? ent[sel0].imm  : '0;
   assign rs_if.DFO_PD_imm1  = iss1 ? ent[sel1].imm  : '0;
   assign rs_if.DFO_PA_rd0   = iss0 ? ent[sel0].rd   : '0;
   assign rs_if.DFO_PA_rd1   = iss1 ? ent[sel1].rd   : '0;
   assign rs_if.DFO_AA_pc0   = iss0 ? ent[sel0].pc   : '0;
   assign rs_if.DFO_AA_pc1   = iss1 ? ent[sel1].pc   : '0;
   assign rs_if.CFO_PC_full  = full;
   assign rs_if.CFO_PC_empty = (count == '0);
   assign rs_if.CDO_PS_count = count;
endmodule

// File: tb/tb_resv_station_gen.sv
// Directed-vector bench for resv_station_gen: one task per scenario, inline checks.
module tb_resv_station_gen;
   logic clk = 1'b0;
   logic CFI_PC_clear;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   resv_station_gen_if #(.W_CNT(4), .N_WB(2), .W_PD_UOPS(6), .W_PD_DATA(32),
                         .W_PA_REG(5), .W_AA_INSTR(32)) rs_if ();

   resv_station_gen #(.DEPTH(8), .W_CNT(4), .N_WB(2), .W_PD_UOPS(6), .W_PD_DATA(32),
                      .W_PA_REG(5), .W_AA_INSTR(32)) dut (
      .clk(clk), .CFI_PC_clear(CFI_PC_clear), .rs_if(rs_if.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      rs_if.DFI_PV_in = 1'b0;  rs_if.DFI_PD_uops = '0;  rs_if.DFI_PA_rd = '0;
      rs_if.DFI_PA_rs = '0;    rs_if.DFI_PA_rt = '0;    rs_if.DFI_PV_rs = 1'b0;
      rs_if.DFI_PV_rt = 1'b0;  rs_if.DFI_PD_rs = '0;    rs_if.DFI_PD_rt = '0;
      rs_if.DFI_PD_imm = '0;   rs_if.DFI_AA_pc = '0;    rs_if.CDI_PV_wb = '0;
      rs_if.CDI_PA_wb = '0;    rs_if.CDI_PD_wb = '0;    rs_if.CFI_PC_stall = 1'b0;
      rs_if.CFI_PC_acc0 = 1'b0; rs_if.CFI_PC_acc1 = 1'b0;
   endtask

   task automatic drive_ins(input logic [31:0] pc, input logic rs_v, input logic [4:0] rs_a,
                            input logic [31:0] rs_d, input logic rt_v, input logic [4:0] rt_a,
                            input logic [31:0] rt_d);
      rs_if.DFI_PV_in = 1'b1;
      rs_if.DFI_PD_uops = 6'h0A;
      rs_if.DFI_PA_rd = 5'd3;
      rs_if.DFI_PV_rs = rs_v;  rs_if.DFI_PA_rs = rs_a;  rs_if.DFI_PD_rs = rs_d;
      rs_if.DFI_PV_rt = rt_v;  rs_if.DFI_PA_rt = rt_a;  rs_if.DFI_PD_rt = rt_d;
      rs_if.DFI_PD_imm = pc + 32'h1000;
      rs_if.DFI_AA_pc = pc;
   endtask

   task automatic drive_wb(input logic [1:0] pv, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1);
      rs_if.CDI_PV_wb = pv;
      rs_if.CDI_PA_wb = {a1, a0};
      rs_if.CDI_PD_wb = {d1, d0};
   endtask

   task automatic do_clear();
      idle();
      CFI_PC_clear = 1'b1;
      tick();
      CFI_PC_clear = 1'b0;
   endtask

   task automatic test_reset();
      do_clear();
      settle();
      n_checks++; if (rs_if.CDO_PS_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", rs_if.CDO_PS_count); end
      n_checks++; if (rs_if.CFO_PC_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", rs_if.CFO_PC_empty); end
      n_checks++; if (rs_if.CFO_PC_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", rs_if.CFO_PC_full); end
      n_checks++; if (rs_if.DFO_PV_iss0 !== 1'b0 || rs_if.DFO_PV_iss1 !== 1'b0) begin n_fail++; $display("FAIL reset_iss: got %b%b expected 00", rs_if.DFO_PV_iss0, rs_if.DFO_PV_iss1); end
      n_checks++; if (rs_if.DFO_PD_uops0 !== 6'h3F || rs_if.DFO_PD_uops1 !== 6'h3F) begin n_fail++; $display("FAIL reset_uops: got %h/%h expected 3f/3f", rs_if.DFO_PD_uops0, rs_if.DFO_PD_uops1); end
      n_checks++; if (rs_if.DFO_AA_pc0 !== 32'h0 || rs_if.DFO_PD_rs1 !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", rs_if.DFO_AA_pc0, rs_if.DFO_PD_rs1); end
   endtask

   task automatic test_basic_issue();
      logic [31:0] exp;
      do_clear();
      exp_q = {};
      for (int k = 0; k < 3; k++) begin
         drive_ins(32'h100 + 32'(4 * k), 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
         exp_q.push_back(32'h100 + 32'(4 * k));
         tick();
      end
      idle();
      rs_if.CFI_PC_acc0 = 1'b1;
      rs_if.CFI_PC_acc1 = 1'b1;
      settle();
      n_checks++; if (rs_if.CDO_PS_count !== 4'd3) begin n_fail++; $display("FAIL basic_count3: got %0d expected 3", rs_if.CDO_PS_count); end
      n_checks++; if (rs_if.DFO_PV_iss0 !== 1'b1 || rs_if.DFO_PV_iss1 !== 1'b1) begin n_fail++; $display("FAIL basic_iss_c1: got %b%b expected 11", rs_if.DFO_PV_iss0, rs_if.DFO_PV_iss1); end
      exp = exp_q.pop_front();
      n_checks++; if (rs_if.DFO_AA_pc0 !== exp) begin n_fail++; $display("FAIL basic_pc0_c1: got %h expected %h", rs_if.DFO_AA_pc0, exp); end
      exp = exp_q.pop_front();
      n_checks++; if (rs_if.DFO_AA_pc1 !== exp) begin n_fail++; $display("FAIL basic_pc1_c1: got %h expected %h", rs_if.DFO_AA_pc1, exp); end
      n_checks++; if (rs_if.DFO_PD_imm0 !== 32'h1100 || rs_if.DFO_PA_rd0 !== 5'd3 || rs_if.DFO_PD_uops0 !== 6'h0A) begin n_fail++; $display("FAIL basic_fields: got imm %h rd %0d uops %h expected 1100 3 0a", rs_if.DFO_PD_imm0, rs_if.DFO_PA_rd0, rs_if.DFO_PD_uops0); end
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (rs_if.DFO_PV_iss0 !== 1'b1 || rs_if.DFO_AA_pc0 !== exp) begin n_fail++; $display("FAIL basic_c2_port0: got %b/%h expected 1/%h", rs_if.DFO_PV_iss0, rs_if.DFO_AA_pc0, exp); end
      n_checks++; if (rs_if.DFO_PV_iss1 !== 1'b0 || rs_if.DFO_PD_uops1 !== 6'h3F) begin n_fail++; $display("FAIL basic_c2_port1: got %b/%h expected 0/3f", rs_if.DFO_PV_iss1, rs_if.DFO_PD_uops1); end
      tick();
      n_checks++; if (rs_if.CDO_PS_count !== 4'd0 || rs_if.CFO_PC_empty !== 1'b1) begin n_fail++; $display("FAIL basic_drained: got count %0d empty %b expected 0 1", rs_if.CDO_PS_count, rs_if.CFO_PC_empty); end
      idle();
   endtask

   task automatic test_wakeup();
      do_clear();
      drive_ins(32'h200, 1'b0, 5'd5, 32'h0, 1'b1, 5'd6, 32'h22);
      tick();
      drive_ins(32'h204, 1'b1, 5'd1, 32'h33, 1'b1, 5'd2, 32'h44);
      tick();
      idle();
      settle();
      n_checks++; if (rs_if.DFO_PV_iss0 !== 1'b1 || rs_if.DFO_AA_pc0 !== 32'h204) begin n_fail++; $display("FAIL wake_young_first: got %b/%h expected 1/204", rs_if.DFO_PV_iss0, rs_if.DFO_AA_pc0); end
      n_checks++; if (rs_if.DFO_PV_iss1 !== 1'b0) begin n_fail++; $display("FAIL wake_waiting_held: got %b expected 0", rs_if.DFO_PV_iss1); end
      rs_if.CFI_PC_acc0 = 1'b1;
      drive_wb(2'b10, 5'd0, 5'd5, 32'h0, 32'hDEAD);
      tick();
      rs_if.CFI_PC_acc0 = 1'b0;
      drive_wb(2'b01, 5'd5, 5'd0, 32'hBEEF, 32'h0);
      settle();
      n_checks++; if (rs_if.DFO_PV_iss0 !== 1'b1 || rs_if.DFO_AA_pc0 !== 32'h200) begin n_fail++; $display("FAIL wake_issue: got %b/%h expected 1/200", rs_if.DFO_PV_iss0, rs_if.DFO_AA_pc0); end
      n_checks++; if (rs_if.DFO_PD_rs0 !== 32'hDEAD || rs_if.DFO_PD_rt0 !== 32'h22) begin n_fail++; $display("FAIL wake_data: got %h/%h expected dead/22", rs_if.DFO_PD_rs0, rs_if.DFO_PD_rt0); end
      n_checks++; if (rs_if.CDO_PS_count !== 4'd1) begin n_fail++; $display("FAIL wake_count: got %0d expected 1", rs_if.CDO_PS_count); end
      tick();
      drive_wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      settle();
      n_checks++; if (rs_if.DFO_PD_rs0 !== 32'hDEAD) begin n_fail++; $display("FAIL wake_no_overwrite: got %h expected dead", rs_if.DFO_PD_rs0); end
      rs_if.CFI_PC_acc0 = 1'b1;
      tick();
      idle();
      n_checks++; if (rs_if.CFO_PC_empty !== 1'b1) begin n_fail++; $display("FAIL wake_drained: got %b expected 1", rs_if.CFO_PC_empty); end
   endtask

   task automatic test_capture_on_insert();
      do_clear();
      drive_ins(32'h300, 1'b1, 5'd1, 32'h11, 1'b0, 5'd7, 32'h0);
      drive_wb(2'b11, 5'd7, 5'd7, 32'h55, 32'h66);
      tick();
      idle();
      settle();
      n_checks++; if (rs_if.DFO_PV_iss0 !== 1'b1 || rs_if.DFO_AA_pc0 !== 32'h300) begin n_fail++; $display("FAIL capture_issue: got %b/%h expected 1/300", rs_if.DFO_PV_iss0, rs_if.DFO_AA_pc0); end
      n_checks++; if (rs_if.DFO_PD_rt0 !== 32'h55) begin n_fail++; $display("FAIL capture_rt_bus0_wins: got %h expected 55", rs_if.DFO_PD_rt0); end
      n_checks++; if (rs_if.DFO_PD_rs0 !== 32'h11) begin n_fail++; $display("FAIL capture_rs_kept: got %h expected 11", rs_if.DFO_PD_rs0); end
      rs_if.CFI_PC_acc0 = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_fill_full();
      logic [31:0] exp;
      do_clear();
      exp_q = {};
      for (int k = 0; k < 8; k++) begin
         drive_ins(32'h400 + 32'(4 * k), 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
         if (k > 0) exp_q.push_back(32'h400 + 32'(4 * k));
         tick();
      end
      drive_ins(32'h4FC, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      settle();
      n_checks++; if (rs_if.CFO_PC_full !== 1'b1 || rs_if.CDO_PS_count !== 4'd8) begin n_fail++; $display("FAIL fill_full: got full %b count %0d expected 1 8", rs_if.CFO_PC_full, rs_if.CDO_PS_count); end
      tick();
      n_checks++; if (rs_if.CDO_PS_count !== 4'd8) begin n_fail++; $display("FAIL fill_drop9: got %0d expected 8", rs_if.CDO_PS_count); end
      rs_if.CFI_PC_acc0 = 1'b1;
      settle();
      n_checks++; if (rs_if.DFO_AA_pc0 !== 32'h400) begin n_fail++; $display("FAIL fill_oldest: got %h expected 400", rs_if.DFO_AA_pc0); end
      tick();
      rs_if.CFI_PC_acc0 = 1'b0;
      settle();
      n_checks++; if (rs_if.CDO_PS_count !== 4'd7 || rs_if.CFO_PC_full !== 1'b0) begin n_fail++; $display("FAIL fill_no_same_cycle_slot: got count %0d full %b expected 7 0", rs_if.CDO_PS_count, rs_if.CFO_PC_full); end
      exp_q.push_back(32'h4FC);
      tick();
      idle();
      settle();
      n_checks++; if (rs_if.CDO_PS_count !== 4'd8 || rs_if.CFO_PC_full !== 1'b1) begin n_fail++; $display("FAIL fill_refill: got count %0d full %b expected 8 1", rs_if.CDO_PS_count, rs_if.CFO_PC_full); end
      rs_if.CFI_PC_acc0 = 1'b1;
      rs_if.CFI_PC_acc1 = 1'b1;
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
         settle();
         if (rs_if.DFO_PV_iss0 === 1'b1) begin
            exp = exp_q.pop_front();
            n_checks++; if (rs_if.DFO_AA_pc0 !== exp) begin n_fail++; $display("FAIL drain_pc0: got %h expected %h", rs_if.DFO_AA_pc0, exp); end
         end
         if (rs_if.DFO_PV_iss1 === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL drain_extra: got pc1 %h expected no issue", rs_if.DFO_AA_pc1);
            end else begin
               exp = exp_q.pop_front();
               if (rs_if.DFO_AA_pc1 !== exp) begin n_fail++; $display("FAIL drain_pc1: got %h expected %h", rs_if.DFO_AA_pc1, exp); end
            end
         end
         tick();
      end
      idle();
      settle();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_left: got %0d left expected 0", exp_q.size()); end
      n_checks++; if (rs_if.CFO_PC_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", rs_if.CFO_PC_empty); end
   endtask

   task automatic test_stall();
      do_clear();
      drive_ins(32'h500, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      tick();
      drive_ins(32'h504, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      tick();
      drive_ins(32'h508, 1'b0, 5'd12, 32'h0, 1'b1, 5'd2, 32'h2);
      tick();
      drive_ins(32'h50C, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      rs_if.CFI_PC_stall = 1'b1;
      rs_if.CFI_PC_acc0 = 1'b1;
      rs_if.CFI_PC_acc1 = 1'b1;
      drive_wb(2'b01, 5'd12, 5'd0, 32'h77, 32'h0);
      settle();
      n_checks++; if (rs_if.DFO_PV_iss0 !== 1'b0 || rs_if.DFO_PV_iss1 !== 1'b0) begin n_fail++; $display("FAIL stall_iss: got %b%b expected 00", rs_if.DFO_PV_iss0, rs_if.DFO_PV_iss1); end
      tick();
      drive_wb(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      settle();
      n_checks++; if (rs_if.CDO_PS_count !== 4'd3) begin n_fail++; $display("FAIL stall_frozen_count: got %0d expected 3", rs_if.CDO_PS_count); end
      tick();
      rs_if.CFI_PC_stall = 1'b0;
      rs_if.DFI_PV_in = 1'b0;
      settle();
      n_checks++; if (rs_if.DFO_AA_pc0 !== 32'h500 || rs_if.DFO_AA_pc1 !== 32'h504) begin n_fail++; $display("FAIL stall_release_order: got %h/%h expected 500/504", rs_if.DFO_AA_pc0, rs_if.DFO_AA_pc1); end
      tick();
      n_checks++; if (rs_if.DFO_PV_iss0 !== 1'b1 || rs_if.DFO_AA_pc0 !== 32'h508 || rs_if.DFO_PD_rs0 !== 32'h77) begin n_fail++; $display("FAIL stall_wakeup_kept: got %b/%h/%h expected 1/508/77", rs_if.DFO_PV_iss0, rs_if.DFO_AA_pc0, rs_if.DFO_PD_rs0); end
      tick();
      idle();
      n_checks++; if (rs_if.CFO_PC_empty !== 1'b1) begin n_fail++; $display("FAIL stall_drained: got %b expected 1", rs_if.CFO_PC_empty); end
   endtask

   task automatic test_clear_override();
      do_clear();
      drive_ins(32'h600, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      tick();
      drive_ins(32'h604, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
      rs_if.CFI_PC_acc0 = 1'b1;
      CFI_PC_clear = 1'b1;
      tick();
      CFI_PC_clear = 1'b0;
      idle();
      settle();
      n_checks++; if (rs_if.CDO_PS_count !== 4'd0 || rs_if.CFO_PC_empty !== 1'b1) begin n_fail++; $display("FAIL clear_count: got count %0d empty %b expected 0 1", rs_if.CDO_PS_count, rs_if.CFO_PC_empty); end
      n_checks++; if (rs_if.DFO_PV_iss0 !== 1'b0 || rs_if.DFO_PD_uops0 !== 6'h3F || rs_if.DFO_AA_pc0 !== 32'h0) begin n_fail++; $display("FAIL clear_port0: got %b/%h/%h expected 0/3f/0", rs_if.DFO_PV_iss0, rs_if.DFO_PD_uops0, rs_if.DFO_AA_pc0); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      CFI_PC_clear = 1'b1;
      idle();
      tick();
      test_reset();
      test_basic_issue();
      test_wakeup();
      test_capture_on_insert();
      test_fill_full();
      test_stall();
      test_clear_override();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
